// File: rtl/range_reader_if.sv
// Result stream from range_reader: one (n, count) pair per valid/ready handshake.
interface range_reader_if;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_n;
    logic [15:0] out_count;
    logic        out_last;

    modport master (output out_valid, out_n, out_count, out_last, input out_ready);
    modport slave  (input out_valid, out_n, out_count, out_last, output out_ready);
endinterface

// File: rtl/range_reader.sv
// Sequencer for the Collatz `range` block: launches a sweep, waits for done,
// reads the RAM back and streams (n, count) pairs while tracking the maximum.
module range_reader #(
    parameter int RAM_WORDS     = 16,
    parameter int RAM_ADDR_BITS = 4,
    parameter int TIMEOUT_BITS  = 24
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req,
    input  logic [31:0]          base,
    output logic                 busy,
    output logic                 rg_go,
    output logic [31:0]          rg_start,
    input  logic                 rg_done,
    input  logic [15:0]          rg_count,
    range_reader_if.master       res,
    output logic [31:0]          max_n,
    output logic [15:0]          max_count,
    output logic                 sweep_done,
    output logic                 timeout
);
    typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, ADDR, FETCH, PRESENT} state_t;

    // Counter value whose increment reaches all-ones: that WAIT cycle is the last one.
    localparam logic [TIMEOUT_BITS-1:0] CNT_LAST = {{(TIMEOUT_BITS-1){1'b1}}, 1'b0};
    localparam logic [RAM_ADDR_BITS-1:0] IDX_LAST = RAM_ADDR_BITS'(RAM_WORDS - 1);

    state_t                   state, state_nxt;
    logic [31:0]              base_q;
    logic [TIMEOUT_BITS-1:0]  cnt;
    logic [RAM_ADDR_BITS-1:0] index;
    logic [31:0]              cur_n;

    assign cur_n = base_q + 32'(index);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req) state_nxt = LAUNCH;
            LAUNCH:  state_nxt = WAIT;
            WAIT: begin
                if (rg_done)              state_nxt = ADDR;
                else if (cnt == CNT_LAST) state_nxt = IDLE;
            end
            ADDR:    state_nxt = FETCH;
            FETCH:   state_nxt = PRESENT;
            PRESENT: if (res.out_ready) state_nxt = res.out_last ? IDLE : ADDR;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy          = (state != IDLE);
        rg_go         = (state == LAUNCH);
        res.out_valid = (state == PRESENT);
        rg_start      = '0;
        case (state)
            // `range` compares start while running, so it stays put through WAIT.
            LAUNCH, WAIT: rg_start = base_q;
            ADDR, FETCH:  rg_start = 32'(index);
            default:      rg_start = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && req) base_q <= base;
        if (state == LAUNCH)     cnt <= '0;
        else if (state == WAIT)  cnt <= cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            index         <= '0;
            res.out_n     <= '0;
            res.out_count <= '0;
            res.out_last  <= 1'b0;
            max_n         <= '0;
            max_count     <= '0;
            sweep_done    <= 1'b0;
            timeout       <= 1'b0;
        end else begin
            sweep_done <= 1'b0;
            case (state)
                IDLE: if (req) begin
                    max_n     <= '0;
                    max_count <= '0;
                    timeout   <= 1'b0;
                end
                WAIT: begin
                    if (rg_done)              index   <= '0;
                    else if (cnt == CNT_LAST) timeout <= 1'b1;
                end
                FETCH: begin
                    res.out_count <= rg_count;
                    res.out_n     <= cur_n;
                    res.out_last  <= (index == IDX_LAST);
                    // Strictly greater: ties keep the earliest n.
                    if (rg_count > max_count) begin
                        max_count <= rg_count;
                        max_n     <= cur_n;
                    end
                end
                PRESENT: if (res.out_ready) begin
                    if (res.out_last) sweep_done <= 1'b1;
                    else              index      <= index + 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_range_reader.sv
// Randomized bench for range_reader with a behavioural `range` model and scoreboard.
module tb_range_reader;
    logic        clk = 1'b0;
    logic        reset, req, busy, rg_go, rg_done, sweep_done, timeout;
    logic [31:0] base, rg_start, max_n;
    logic [15:0] rg_count, max_count;
    logic        t_req, t_busy, t_rg_go, t_rg_done, t_sweep_done, t_timeout;
    logic [31:0] t_base, t_rg_start, t_max_n;
    logic [15:0] t_rg_count, t_max_count;

    range_reader_if rif();
    range_reader_if tif();

    always #5 clk = ~clk;

    range_reader dut (
        .clk(clk), .reset(reset), .req(req), .base(base), .busy(busy),
        .rg_go(rg_go), .rg_start(rg_start), .rg_done(rg_done), .rg_count(rg_count),
        .res(rif.master), .max_n(max_n), .max_count(max_count),
        .sweep_done(sweep_done), .timeout(timeout)
    );

    range_reader #(.TIMEOUT_BITS(4)) dut_to (
        .clk(clk), .reset(reset), .req(t_req), .base(t_base), .busy(t_busy),
        .rg_go(t_rg_go), .rg_start(t_rg_start), .rg_done(t_rg_done), .rg_count(t_rg_count),
        .res(tif.master), .max_n(t_max_n), .max_count(t_max_count),
        .sweep_done(t_sweep_done), .timeout(t_timeout)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Collatz trajectory length including both ends (n=1 -> 1, n=3 -> 8); 0 never terminates.
    function automatic logic [15:0] collatz(input logic [31:0] n);
        longint unsigned v = 64'(n);
        int c = 1;
        if (n == 0) return 16'd0;
        while (v != 1 && c < 4000) begin
            v = v[0] ? 3 * v + 1 : v / 2;
            c++;
        end
        return 16'(c);
    endfunction

    // Behavioural `range`: fills its RAM on go, pulses done after a random latency,
    // and serves registered reads addressed by rg_start.
    logic [15:0] mem [16];
    int          lat_cnt;
    int          gos = 0;
    bit          tie_mode = 0;
    logic [31:0] m_start;

    always @(posedge clk) begin
        rg_count <= mem[rg_start[3:0]];
        rg_done  <= 1'b0;
        if (reset) begin
            lat_cnt <= 0;
        end else if (rg_go) begin
            gos     <= gos + 1;
            m_start <= rg_start;
            lat_cnt <= $urandom_range(3, 30);
            for (int i = 0; i < 16; i++)
                mem[i] <= tie_mode ? 16'($urandom_range(1, 4)) : collatz(rg_start + 32'(i));
        end else if (lat_cnt > 0) begin
            if (lat_cnt == 1) rg_done <= 1'b1;
            lat_cnt <= lat_cnt - 1;
        end
    end

    logic [15:0] table_k [16] = '{16'd1, 16'd2, 16'd8, 16'd3, 16'd6, 16'd9, 16'd17, 16'd4,
                                  16'd20, 16'd7, 16'd15, 16'd10, 16'd10, 16'd18, 16'd18, 16'd5};
    logic [15:0] first_count;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_sweep(input logic [31:0] b, input bit rand_ready, input bit noise,
                             input int stop_at);
        int got = 0, pulses = 0, gos0, idx;
        bit stall = 0, finished = 0;
        logic [31:0] hold_n, exp_n, emn;
        logic [15:0] hold_c, exp_c, emc;
        logic        hold_l;
        emc = '0;
        emn = '0;
        gos0 = gos;
        req = 1'b1;
        base = b;
        tick();
        req = 1'b0;
        base = $urandom;
        check("accept_busy", 64'(busy), 64'd1);
        check("accept_max_clear", {max_n, 16'd0, max_count}, 64'd0);
        for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
            if (stop_at >= 0 && got == stop_at) rif.out_ready = 1'b0;
            else rif.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            req = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            if (sweep_done) pulses++;
            if (rif.out_valid) begin
                if (stall)
                    check("hold_stable", {rif.out_n, rif.out_count, 15'd0, rif.out_last},
                          {hold_n, hold_c, 15'd0, hold_l});
                if (stop_at >= 0 && got == stop_at) begin
                    tick();
                    tick();
                    check("stop_hold_valid", 64'(rif.out_valid), 64'd1);
                    reset = 1'b1;
                    tick();
                    reset = 1'b0;
                    check("midreset_ctrl", {busy, rg_go, rif.out_valid, rif.out_last,
                          sweep_done, timeout}, 64'd0);
                    check("midreset_data", {rif.out_n, rif.out_count, 16'd0}, 64'd0);
                    check("midreset_max", {max_n, max_count, 16'd0}, 64'd0);
                    check("midreset_rg_start", 64'(rg_start), 64'd0);
                    return;
                end
                if (rif.out_ready) begin
                    idx = got;
                    exp_n = b + 32'(idx);
                    if (tie_mode)    exp_c = mem[idx];
                    else if (b == 1) exp_c = table_k[idx];
                    else             exp_c = collatz(exp_n);
                    if (got == 0) first_count = rif.out_count;
                    check("result_n", 64'(rif.out_n), 64'(exp_n));
                    check("result_count", 64'(rif.out_count), 64'(exp_c));
                    check("result_last", 64'(rif.out_last), 64'(idx == 15));
                    if (exp_c > emc) begin
                        emc = exp_c;
                        emn = exp_n;
                    end
                    got++;
                    if (idx == 15) begin
                        finished = 1;
                        if (noise) req = 1'b1;
                    end
                end
                stall = !rif.out_ready;
                hold_n = rif.out_n;
                hold_c = rif.out_count;
                hold_l = rif.out_last;
            end else begin
                stall = 0;
            end
            tick();
        end
        check("sweep_finished", 64'(finished), 64'd1);
        req = 1'b0;
        check("done_pulse", {sweep_done, busy, rif.out_valid}, {1'b1, 1'b0, 1'b0});
        check("early_done_pulses", 64'(pulses), 64'd0);
        check("max_count", 64'(max_count), 64'(emc));
        check("max_n", 64'(max_n), 64'(emn));
        check("single_go", 64'(gos - gos0), 64'd1);
        tick();
        check("idle_after_exit", {sweep_done, busy}, 64'd0);
        check("max_persist", {max_n, max_count, 16'd0}, {emn, emc, 16'd0});
    endtask

    initial begin
        int n;
        bit saw_valid;
        reset = 1'b1;
        req = 1'b0;
        base = '0;
        rif.out_ready = 1'b0;
        tif.out_ready = 1'b1;
        t_req = 1'b0;
        t_base = 32'd5;
        t_rg_done = 1'b0;
        t_rg_count = '0;
        repeat (3) tick();
        check("reset_ctrl", {busy, rg_go, rif.out_valid, rif.out_last, sweep_done, timeout}, 64'd0);
        check("reset_data", {rif.out_n, rif.out_count, 16'd0}, 64'd0);
        check("reset_max", {max_n, max_count, 16'd0}, 64'd0);
        reset = 1'b0;
        tick();

        run_sweep(32'd1, 0, 0, -1);
        run_sweep(32'd1, 1, 1, -1);
        run_sweep(32'd27, 1, 0, -1);
        check("first_count_27", 64'(first_count), 64'd112);
        run_sweep(32'hFFFF_FFF8, 1, 0, -1);
        tie_mode = 1;
        run_sweep($urandom, 1, 1, -1);
        run_sweep($urandom, 1, 0, -1);
        tie_mode = 0;
        run_sweep(32'd1, 0, 0, 5);
        run_sweep(32'd1, 0, 0, -1);

        t_req = 1'b1;
        tick();
        t_req = 1'b0;
        n = 0;
        saw_valid = 0;
        while (t_busy && n < 100) begin
            n++;
            if (tif.out_valid) saw_valid = 1;
            tick();
        end
        check("timeout_busy_cycles", 64'(n), 64'd16);
        check("timeout_flag", {t_timeout, t_busy, saw_valid}, {1'b1, 1'b0, 1'b0});
        repeat (3) tick();
        check("timeout_sticky", 64'(t_timeout), 64'd1);
        t_req = 1'b1;
        tick();
        t_req = 1'b0;
        check("timeout_cleared", {t_timeout, t_busy}, {1'b0, 1'b1});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/range_reader.md
Name: range_reader

Overview:
- Sequencer for the Collatz `range` block; it sits between the top level and `range`.
- Launches a sweep of RAM_WORDS consecutive start values, waits for `range` to fill its RAM, then reads every word back.
- Streams each (n, count) pair out over a valid/ready handshake.
- Tracks the maximum count and the n that produced it, and flags a hung sweep via a timeout.

Parameters:
- RAM_WORDS, 16, number of words `range` stores; also the number of results streamed per sweep.
- RAM_ADDR_BITS, 4, `range` RAM address width; RAM_WORDS <= 2^RAM_ADDR_BITS.
- TIMEOUT_BITS, 24, width of the wait-for-done counter; timeout fires when it reaches all-ones.

Ports:
- clk  in  1  clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- req  in  1  start a sweep; sampled only in IDLE.
- base  in  32  first n of the sweep; captured on accepted req.
- busy  out  1  high in every state except IDLE.
- rg_go  out  1  drives `range` go.
- rg_start  out  32  drives `range` start (start value, then read address).
- rg_done  in  1  `range` done pulse.
- rg_count  in  16  `range` count (registered RAM read, 1-cycle latency).
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts the result.
- out_n  out  32  n for the current result (base + index, mod 2^32).
- out_count  out  16  iteration count for out_n.
- out_last  out  1  high with the final result of a sweep.
- max_n  out  32  n with the largest count so far this sweep.
- max_count  out  16  largest count so far this sweep.
- sweep_done  out  1  one-cycle pulse after the last result is accepted.
- timeout  out  1  sticky; set when rg_done never arrives; cleared by reset or an accepted req.

Behaviour:
- Reset values: all outputs 0; state IDLE; index 0. Reset in any state returns to IDLE that cycle-edge with rg_go=0; no partial output is held.
- IDLE: rg_start=0. On req=1, capture base_q=base, clear max_n/max_count/timeout, and go to LAUNCH.
- LAUNCH (1 cycle): rg_go=1, rg_start=base_q. Go to WAIT and clear the timeout counter.
- WAIT: rg_start is held at base_q, because `range` compares start while running.
  - On rg_done=1, go to ADDR with index=0.
  - Otherwise increment the counter. At all-ones, set timeout=1 and go to IDLE.
- ADDR: rg_start = zero-extended index[RAM_ADDR_BITS-1:0]. Go to FETCH.
- FETCH: rg_start is held at the same address, so rg_count is now mem[index]. Then:
  - register out_count=rg_count, out_n=base_q+index, out_last=(index==RAM_WORDS-1), out_valid=1;
  - update max: if rg_count > max_count, load max_count/max_n (strictly greater, so ties keep the earliest n);
  - go to PRESENT.
- PRESENT: out_valid=1 and out_* stay stable until out_ready=1.
  - On a handshake with out_last=1, go to IDLE, pulse sweep_done, and drop out_valid.
  - Otherwise increment index and go to ADDR, dropping out_valid.
- Throughput: at most one result per 3 cycles. out_valid never depends combinationally on out_ready.
- req while busy is ignored. req in the same cycle as a sweep_done exit is ignored; it must be reasserted in IDLE.
- out_n arithmetic is 32-bit wrap: base=32'hFFFF_FFFF gives out_n=0 at index 1.
- rg_done seen outside WAIT is ignored.
- max_n/max_count stay valid after the sweep until the next accepted req.

Test Plan:
- base=1, out_ready=1 always, with real `range` -> 16 results n=1..16, counts 1,2,8,3,6,9,17,4,20,7,15,10,10,18,18,5; out_last only on n=16; max_count=20, max_n=9; one sweep_done pulse.
- Same sweep with out_ready toggled pseudo-randomly -> identical sequence, no duplicates or drops, and out_* stable while out_valid=1 and out_ready=0.
- base=27 -> first result count=112. Then base=32'hFFFF_FFF8 with a behavioural `range` model -> out_n wraps past 0 correctly.
- rg_done tied to 0, TIMEOUT_BITS=4 -> timeout=1 after 15 WAIT cycles, busy=0, no out_valid. A new req clears timeout.
- reset asserted mid-PRESENT (index 5) -> next cycle all outputs 0, busy=0. A following req with base=1 produces a full correct sweep.
- req pulsed during WAIT and PRESENT -> ignored. Tie case: counts 10,10 at n=12,13 -> max_n stays 12.
